// File: rtl/im_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : im_pkg
//  Description : Shared defaults and helpers for the im_sync instruction
//                memory: geometry, base address, NOP word and the
//                address range check used by the fetch decode.
//  Revision    : 1.0  initial release
// ============================================================================
package im_pkg;

  // Default geometry: 2**11 words of 32 bits = 8 KB.
  localparam int          IM_DATA_W    = 32;
  localparam int          IM_ADDR_W    = 11;
  localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;

  // Word presented on an illegal fetch and before the first accepted fetch.
  localparam logic [31:0] IM_NOP_WORD  = 32'h0000_0000;

  // Decoded view of a fetch address.
  typedef struct packed {
    logic aligned;   // pc[1:0] == 0
    logic in_range;  // offset from base lies inside the array
  } im_decode_t;

  // True when pc lies inside the 4*2**addr_w byte window starting at base.
  // The subtraction wraps, so addresses below base land far out of range.
  function automatic logic im_in_range(input logic [31:0]  pc,
                                       input logic [31:0]  base,
                                       input int unsigned  addr_w);
    logic [31:0] off;
    off         = pc - base;
    im_in_range = ((off >> (addr_w + 2)) == 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/im_sync_if.sv
`default_nettype none
// ============================================================================
//  Module      : im_sync_if
//  Description : Bundle of the fetch port and loader port of im_sync.
//                master = pipeline/loader side, slave = memory side.
//  Ports       : fetch_req, stall, pc        -> fetch request
//                dout, dout_valid, addr_err  <- fetch response
//                ld_we, ld_addr, ld_data     -> loader word write
//                ld_count                    <- saturating write counter
//  Revision    : 1.0  initial release
// ============================================================================
interface im_sync_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);

  logic              fetch_req;
  logic              stall;
  logic [31:0]       pc;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              addr_err;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W:0]   ld_count;

  modport master (
    output fetch_req, stall, pc, ld_we, ld_addr, ld_data,
    input  dout, dout_valid, addr_err, ld_count
  );

  modport slave (
    input  fetch_req, stall, pc, ld_we, ld_addr, ld_data,
    output dout, dout_valid, addr_err, ld_count
  );

endinterface
`default_nettype wire

// File: rtl/im_bram_core.sv
`default_nettype none
// ============================================================================
//  Module      : im_bram_core
//  Description : Single-clock simple dual-port RAM, one write port and one
//                registered read port. A read and a write to the same word
//                in the same cycle return the new data (write-first).
//                Written in the plain template block-RAM inference expects.
//  Ports       : clk                        rising-edge clock
//                i_we / i_waddr / i_wdata   write port
//                i_re / i_raddr / o_rdata   read port, data valid one cycle
//                                           after i_re, held while i_re=0
//  Revision    : 1.0  initial release
// ============================================================================
module im_bram_core #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              i_we,
  input  wire logic [ADDR_W-1:0] i_waddr,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic              i_re,
  input  wire logic [ADDR_W-1:0] i_raddr,
  output logic      [DATA_W-1:0] o_rdata
);

  localparam int c_DEPTH = 1 << ADDR_W;

  // Contents are never reset; the owner masks the output until a real read.
  logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      // Bypass the array on an address match so the reader sees the word
      // being written this cycle.
      if (i_we && (i_waddr == i_raddr)) begin
        r_rdata <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_raddr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/im_sync.sv
`default_nettype none
// ============================================================================
//  Module      : im_sync
//  Description : Parametrised instruction memory with a synchronous-read
//                fetch port for the IF stage and a word-write loader port.
//                Decodes pc against BASE_ADDR, flags misaligned or
//                out-of-range fetches, holds its outputs on stall and counts
//                loader writes (saturating at the array depth).
//  Ports       : clk        rising-edge clock
//                rst_n      synchronous active-low reset
//                io_bus     im_sync_if.slave:
//                             fetch_req, stall, pc   fetch request
//                             dout, dout_valid,      fetch response, one
//                             addr_err               cycle after acceptance
//                             ld_we, ld_addr,        loader word write
//                             ld_data
//                             ld_count               writes since reset
//  Revision    : 1.0  initial release
// ============================================================================
module im_sync
  import im_pkg::*;
#(
  parameter int          ADDR_W    = IM_ADDR_W,
  parameter int          DATA_W    = IM_DATA_W,
  parameter logic [31:0] BASE_ADDR = IM_BASE_ADDR,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IM_NOP_WORD)
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  im_sync_if.slave   io_bus
);

  // Counter ceiling: one write per word of the array.
  localparam logic [ADDR_W:0] c_LD_MAX = {1'b1, {ADDR_W{1'b0}}};

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  im_decode_t        w_dec;
  logic              w_legal;
  logic [ADDR_W-1:0] w_idx;

  assign w_dec.aligned  = (io_bus.pc[1:0] == 2'b00);
  assign w_dec.in_range = im_in_range(io_bus.pc, BASE_ADDR, ADDR_W);
  assign w_legal        = w_dec.aligned & w_dec.in_range;
  // Word index is the byte offset from the base, divided by four.
  assign w_idx          = ADDR_W'((io_bus.pc - BASE_ADDR) >> 2);

  // --------------------------------------------------------------------------
  // Request qualification
  // --------------------------------------------------------------------------
  logic w_accept;
  logic w_rd_en;
  logic w_wr_en;

  assign w_accept = io_bus.fetch_req & ~io_bus.stall;
  // Gating with rst_n drops any request or write present in the reset cycle.
  // Illegal fetches never touch the array.
  assign w_rd_en  = rst_n & w_accept & w_legal;
  assign w_wr_en  = rst_n & io_bus.ld_we;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_rdata;

  im_bram_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (io_bus.ld_addr),
    .i_wdata (io_bus.ld_data),
    .i_re    (w_rd_en),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  // --------------------------------------------------------------------------
  // Response and loader-counter registers
  // --------------------------------------------------------------------------
  logic            r_valid;
  logic            r_err;
  logic            r_use_nop;   // present NOP_WORD instead of RAM data
  logic [ADDR_W:0] r_ld_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_use_nop  <= 1'b1;
      r_ld_count <= '0;
    end else begin
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_err     <= ~w_legal;
        r_use_nop <= ~w_legal;
      end else if (!io_bus.stall) begin
        // Idle cycle: drop valid, keep dout and err as they were.
        r_valid <= 1'b0;
      end

      if (io_bus.ld_we && (r_ld_count != c_LD_MAX)) begin
        r_ld_count <= r_ld_count + 1'b1;
      end
    end
  end

  // The core's read register only updates on an accepted legal fetch, so
  // during stall or idle cycles it holds; r_use_nop covers both the illegal
  // case and the window before the first real read (no X on dout).
  assign io_bus.dout       = r_use_nop ? NOP_WORD : w_rdata;
  assign io_bus.dout_valid = r_valid;
  assign io_bus.addr_err   = r_err;
  assign io_bus.ld_count   = r_ld_count;

endmodule
`default_nettype wire

// File: doc/im_sync.md
Name: im_sync

Overview:
- Parametrised successor to the fixed 8 KB instruction memory.
- Provides a synchronous-read instruction fetch port for the pipeline IF stage, with stall hold and out-of-range/misalignment detection.
- Adds a word-write load port so the bootloader (UART/debug) can fill instruction RAM at run time.
- Sits between the PC register and the IF/ID pipeline register. Maps to one BRAM block.

Parameters:
- ADDR_W, 11, word-address bits; depth = 2**ADDR_W words (11 gives 8 KB).
- DATA_W, 32, instruction word width.
- BASE_ADDR, 32'h0000_3000, byte address of word 0.
- NOP_WORD, 32'h0000_0000, word returned on fault or before the first valid fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- fetch_req  in  1  IF stage requests a word at pc this cycle.
- stall  in  1  pipeline stall; hold all fetch outputs.
- pc  in  32  byte address of the instruction.
- dout  out  DATA_W  fetched instruction.
- dout_valid  out  1  dout corresponds to an accepted request.
- addr_err  out  1  the accepted request was misaligned or out of range.
- ld_we  in  1  loader word write strobe.
- ld_addr  in  ADDR_W  loader word index.
- ld_data  in  DATA_W  loader write data.
- ld_count  out  ADDR_W+1  number of loader writes since reset; saturates.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - dout=NOP_WORD, dout_valid=0, addr_err=0, ld_count=0.
  - RAM contents are not cleared.
  - A request or write present in the reset cycle is discarded.
- Address decode (combinational, on pc):
  - off = pc - BASE_ADDR (32-bit, wrapping).
  - Aligned when pc[1:0]==0.
  - In range when off < 4*2**ADDR_W, i.e. off[31:ADDR_W+2]==0.
  - Word index = off[ADDR_W+1:2].
- Fetch acceptance: accepted when fetch_req=1 and stall=0.
- Fetch latency is 1 cycle. When a fetch is accepted, at the next edge:
  - Legal address: dout=RAM[index], dout_valid=1, addr_err=0.
  - Illegal address: dout=NOP_WORD, dout_valid=1, addr_err=1. No RAM read.
- fetch_req=0 and stall=0: dout_valid=0 next cycle; dout holds its last value.
- stall=1: dout, dout_valid and addr_err hold exactly, regardless of fetch_req, pc or loader writes. The RAM read is not re-issued.
- Load port:
  - ld_we=1 writes RAM[ld_addr]=ld_data at the edge. Writes are not blocked by stall.
  - ld_count increments by 1 per write and saturates at 2**ADDR_W.
- Simultaneous write and accepted fetch to the same word: write-first. dout returns the new ld_data.
- Writes to other words do not disturb the fetch.
- Back-to-back fetches at one per cycle are fully supported (throughput 1 word/cycle).
- Reset asserted mid-stall or mid-load overrides everything. State returns to the reset values on that edge.
- No X on dout after reset: unread locations are never presented, because dout shows NOP_WORD until the first accepted fetch.

Decomposition:
- Shared package im_pkg:
  - IM_DATA_W, IM_ADDR_W and IM_BASE_ADDR defaults.
  - NOP_WORD constant.
  - Function im_in_range(pc, base, addr_w).
- Sub-module im_bram_core: single-clock simple dual-port RAM.
  - Write port: we/waddr/wdata. Read port: re/raddr/rdata.
  - Registered read, write-first on address match.
  - Coded for BRAM inference.
- im_sync contains the decode, the stall/valid/err registers, the ld_count counter and the NOP substitution mux.

Test Plan:
- Reset and first fetch: hold rst_n=0 for 3 cycles, then load 0x3C080001 at word 0, then fetch pc=0x3000. Required: dout=0, valid=0 during reset; one cycle after the fetch, dout=0x3C080001, valid=1, err=0; ld_count=1.
- Sequential fetch: load words 0..7 with 0x1000_0000+i, then fetch pc=0x3000..0x301C on consecutive cycles. Required: dout follows one cycle behind with values 0x1000_0000..0x1000_0007 and valid held at 1.
- Stall hold: fetch 0x3004, then assert stall for 4 cycles while pc changes and ld_we writes word 1 with 0xDEADBEEF. Required: dout stays 0x1000_0001. After the stall releases, fetching 0x3004 returns 0xDEADBEEF.
- Illegal addresses: fetch pc=0x3002, then pc=0x5000 (with ADDR_W=11), then pc=0x2FFC. Required: each returns dout=NOP_WORD, valid=1, err=1, and the RAM is untouched.
- Collision: in the same cycle, ld_we writes word 5 with 0xCAFEF00D and a fetch requests pc=0x3014. Required: dout=0xCAFEF00D next cycle.
- Saturation and mid-operation reset: with ADDR_W=2, issue 6 writes. Required: ld_count stops at 4. Then pulse rst_n=0 during a stall. Required: dout=NOP_WORD, valid=0, ld_count=0, and the RAM keeps its data, so a subsequent fetch returns the last written word.
